// File: rtl/btb_pkg.sv
// Shared types, confidence constants and address-split helpers for the set-associative BTB.
// Optional feature macro: BTB_CONF_EN (per-entry 2-bit confidence counters).
package btb_pkg;

   typedef logic [1:0] conf_t;

   localparam conf_t CONF_INIT   = 2'd2;
   localparam conf_t CONF_MAX    = 2'd3;
   localparam conf_t CONF_THRESH = 2'd2;

   // Callers narrow the 32-bit result to their own index/tag width.
   function automatic logic [31:0] btb_index(input logic [63:0] pc,
                                             input int unsigned lsb,
                                             input int unsigned idx_w);
      logic [63:0] sh;
      sh = (pc >> lsb) & ((64'd1 << idx_w) - 64'd1);
      return sh[31:0];
   endfunction

   function automatic logic [31:0] btb_tag(input logic [63:0] pc,
                                           input int unsigned lsb,
                                           input int unsigned idx_w,
                                           input int unsigned tag_w);
      logic [63:0] sh;
      sh = (pc >> (lsb + idx_w)) & ((64'd1 << tag_w) - 64'd1);
      return sh[31:0];
   endfunction

   // Flag fields of an entry; tag and target widths are fixed by the BTB instance.
   typedef struct packed {
      logic  valid;
      conf_t conf;
   } btb_flags_t;

endpackage

// File: rtl/btb_victim_sel.sv
// Combinational victim choice: lowest invalid way, then lowest zero-confidence way, then the RR way.
// zero_mask is tied low when BTB_CONF_EN is not defined.
module btb_victim_sel #(
   parameter int WAYS  = 2,
   parameter int WAY_W = 1
) (
   input  logic [WAYS-1:0]  inv_mask,
   input  logic [WAYS-1:0]  zero_mask,
   input  logic [WAY_W-1:0] rr_ptr,
   output logic [WAY_W-1:0] victim
);

   always_comb begin
      logic found;
      victim = rr_ptr;
      found  = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!found && inv_mask[w]) begin
            victim = WAY_W'(w);
            found  = 1'b1;
         end
      end
      for (int w = 0; w < WAYS; w++) begin
         if (!found && zero_mask[w]) begin
            victim = WAY_W'(w);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative partial-tag BTB: registered one-cycle lookup, execute-side update, single-cycle flush.
// Define BTB_CONF_EN to add 2-bit confidence counters that gate predictions and steer replacement.
module btb_assoc
   import btb_pkg::*;
#(
   parameter int PC_W      = 32,
   parameter int SETS      = 128,
   parameter int WAYS      = 2,
   parameter int TAG_W     = 12,
   parameter int INDEX_LSB = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            query_valid,
   input  logic [PC_W-1:0] query_pc,
   output logic            pred_valid,
   output logic [PC_W-1:0] pred_pc,
   input  logic            update_valid,
   input  logic [PC_W-1:0] update_pc,
   input  logic [PC_W-1:0] update_target,
   input  logic            update_taken,
   input  logic            flush
);

   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef struct packed {
      btb_flags_t       flags;
      logic [TAG_W-1:0] tag;
      logic [PC_W-1:0]  target;
   } entry_t;

   entry_t mem_q [SETS][WAYS];
   entry_t mem_d [SETS][WAYS];

   logic            pred_valid_q, pred_valid_d;
   logic [PC_W-1:0] pred_pc_q, pred_pc_d;

   logic [IDX_W-1:0] q_idx, u_idx;
   logic [TAG_W-1:0] q_tag, u_tag;
   logic             q_hit;
   logic [PC_W-1:0]  q_tgt;
   logic             u_hit;
   logic [WAY_W-1:0] u_way, vic_way, rr_cur;
   logic [WAYS-1:0]  inv_mask, zero_mask;

   assign q_idx = IDX_W'(btb_index(64'(query_pc), INDEX_LSB, IDX_W));
   assign q_tag = TAG_W'(btb_tag(64'(query_pc), INDEX_LSB, IDX_W, TAG_W));
   assign u_idx = IDX_W'(btb_index(64'(update_pc), INDEX_LSB, IDX_W));
   assign u_tag = TAG_W'(btb_tag(64'(update_pc), INDEX_LSB, IDX_W, TAG_W));

   // Lookup reads pre-edge state, so a same-cycle update is not visible here.
   always_comb begin
      q_hit = 1'b0;
      q_tgt = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (mem_q[q_idx][w].flags.valid && mem_q[q_idx][w].tag == q_tag) begin
`ifdef BTB_CONF_EN
            q_hit = (mem_q[q_idx][w].flags.conf >= CONF_THRESH);
`else
            q_hit = 1'b1;
`endif
            q_tgt = mem_q[q_idx][w].target;
         end
      end
      pred_valid_d = query_valid && !flush && q_hit;
      pred_pc_d    = pred_valid_d ? q_tgt : '0;
   end

   always_comb begin
      u_hit     = 1'b0;
      u_way     = '0;
      inv_mask  = '0;
      zero_mask = '0;
      for (int w = 0; w < WAYS; w++) begin
         inv_mask[w] = !mem_q[u_idx][w].flags.valid;
`ifdef BTB_CONF_EN
         zero_mask[w] = mem_q[u_idx][w].flags.valid && (mem_q[u_idx][w].flags.conf == 2'd0);
`endif
         if (mem_q[u_idx][w].flags.valid && mem_q[u_idx][w].tag == u_tag) begin
            u_hit = 1'b1;
            u_way = WAY_W'(w);
         end
      end
   end

   btb_victim_sel #(.WAYS(WAYS), .WAY_W(WAY_W)) u_victim (
      .inv_mask  (inv_mask),
      .zero_mask (zero_mask),
      .rr_ptr    (rr_cur),
      .victim    (vic_way)
   );

   always_comb begin
      mem_d = mem_q;
      if (flush) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               mem_d[s][w].flags.valid = 1'b0;
      end else if (update_valid) begin
         if (u_hit) begin
            if (update_taken) begin
               mem_d[u_idx][u_way].target = update_target;
`ifdef BTB_CONF_EN
               if (mem_q[u_idx][u_way].flags.conf != CONF_MAX)
                  mem_d[u_idx][u_way].flags.conf = mem_q[u_idx][u_way].flags.conf + 2'd1;
`endif
            end else begin
`ifdef BTB_CONF_EN
               if (mem_q[u_idx][u_way].flags.conf != 2'd0)
                  mem_d[u_idx][u_way].flags.conf = mem_q[u_idx][u_way].flags.conf - 2'd1;
`else
               mem_d[u_idx][u_way].flags.valid = 1'b0;
`endif
            end
         end else if (update_taken) begin
            mem_d[u_idx][vic_way].flags.valid = 1'b1;
            mem_d[u_idx][vic_way].flags.conf  = CONF_INIT;
            mem_d[u_idx][vic_way].tag         = u_tag;
            mem_d[u_idx][vic_way].target      = update_target;
         end
      end
   end

   // The RR pointer only moves when an allocation had to evict a valid way.
   generate
      if (WAYS > 1) begin : g_rr
         logic [WAY_W-1:0] rr_q [SETS];
         logic [WAY_W-1:0] rr_d [SETS];
         logic             rr_adv;

         assign rr_adv = update_valid && update_taken && !u_hit && !(|inv_mask);
         assign rr_cur = rr_q[u_idx];

         always_comb begin
            rr_d = rr_q;
            if (flush) begin
               for (int s = 0; s < SETS; s++) rr_d[s] = '0;
            end else if (rr_adv) begin
               rr_d[u_idx] = rr_q[u_idx] + WAY_W'(1);
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
            end else begin
               rr_q <= rr_d;
            end
         end
      end else begin : g_no_rr
         assign rr_cur = '0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         pred_valid_q <= 1'b0;
         pred_pc_q    <= '0;
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               mem_q[s][w].flags.valid <= 1'b0;
      end else begin
         pred_valid_q <= pred_valid_d;
         pred_pc_q    <= pred_pc_d;
         mem_q        <= mem_d;
      end
   end

   assign pred_valid = pred_valid_q;
   assign pred_pc    = pred_pc_q;

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (default parameters); expectations queued at drive time, checked after the edge.
module tb_btb_assoc;

   logic        clk = 1'b0;
   logic        rst;
   logic        query_valid;
   logic [31:0] query_pc;
   logic        pred_valid;
   logic [31:0] pred_pc;
   logic        update_valid;
   logic [31:0] update_pc;
   logic [31:0] update_target;
   logic        update_taken;
   logic        flush;

   typedef struct packed {
      logic        v;
      logic [31:0] pc;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    total  = 0;
   int    passed = 0;

   always #5 clk = ~clk;

   btb_assoc dut (
      .clk           (clk),
      .rst           (rst),
      .query_valid   (query_valid),
      .query_pc      (query_pc),
      .pred_valid    (pred_valid),
      .pred_pc       (pred_pc),
      .update_valid  (update_valid),
      .update_pc     (update_pc),
      .update_target (update_target),
      .update_taken  (update_taken),
      .flush         (flush)
   );

   task automatic step(input string nm, input logic qv, input logic [31:0] qpc,
                       input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                       input logic ut, input logic fl, input logic ev, input logic [31:0] epc);
      exp_t e;
      string n;
      query_valid   = qv;
      query_pc      = qpc;
      update_valid  = uv;
      update_pc     = upc;
      update_target = utgt;
      update_taken  = ut;
      flush         = fl;
      exp_q.push_back('{v: ev, pc: epc});
      name_q.push_back(nm);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      assert (pred_valid === e.v && pred_pc === e.pc) passed++;
      else $error("FAIL %s: observed valid=%0b pc=%h, expected valid=%0b pc=%h",
                  n, pred_valid, pred_pc, e.v, e.pc);
   endtask

   // Query-only and update-only shorthands.
   task automatic query(input string nm, input logic [31:0] qpc, input logic ev, input logic [31:0] epc);
      step(nm, 1'b1, qpc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, ev, epc);
   endtask

   task automatic update(input string nm, input logic [31:0] upc, input logic [31:0] utgt, input logic ut);
      step(nm, 1'b0, 32'h0, 1'b1, upc, utgt, ut, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      step("reset0", 1'b1, 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      step("reset1", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      rst = 1'b0;

      query("cold_miss", 32'h1000, 1'b0, 32'h0);
      step("same_cycle_upd", 1'b1, 32'h1000, 1'b1, 32'h1000, 32'h2000, 1'b1, 1'b0, 1'b0, 32'h0);
      query("hit_after_upd", 32'h1000, 1'b1, 32'h2000);
      query("other_set_miss", 32'h1004, 1'b0, 32'h0);

      // Index 0 with tags 8,9,10,11: two ways, round-robin eviction.
      update("alloc_1200", 32'h1200, 32'h2200, 1'b1);
      query("both_ways_1000", 32'h1000, 1'b1, 32'h2000);
      update("alloc_1400", 32'h1400, 32'h2400, 1'b1);
      query("evicted_1000", 32'h1000, 1'b0, 32'h0);
      query("hit_1200", 32'h1200, 1'b1, 32'h2200);
      query("hit_1400", 32'h1400, 1'b1, 32'h2400);
      update("alloc_1600", 32'h1600, 32'h2600, 1'b1);
      query("evicted_1200", 32'h1200, 1'b0, 32'h0);
      query("hit_1600", 32'h1600, 1'b1, 32'h2600);
      query("kept_1400", 32'h1400, 1'b1, 32'h2400);

      update("retarget_1400", 32'h1400, 32'h2800, 1'b1);
      query("retarget_hit", 32'h1400, 1'b1, 32'h2800);
      query("retarget_kept", 32'h1600, 1'b1, 32'h2600);

      update("nt_nomatch", 32'h1800, 32'h0, 1'b0);
      query("nt_nomatch_1400", 32'h1400, 1'b1, 32'h2800);
      query("nt_nomatch_1600", 32'h1600, 1'b1, 32'h2600);

      update("alloc_1004", 32'h1004, 32'h5000, 1'b1);
      query("hit_1004", 32'h1004, 1'b1, 32'h5000);
      update("nt_1004", 32'h1004, 32'h0, 1'b0);
      query("after_nt_1004", 32'h1004, 1'b0, 32'h0);
`ifdef BTB_CONF_EN
      update("conf_up1", 32'h1004, 32'h5000, 1'b1);
      update("conf_up2", 32'h1004, 32'h5000, 1'b1);
      query("conf_sat_hit", 32'h1004, 1'b1, 32'h5000);
`else
      update("realloc_1004", 32'h1004, 32'h5004, 1'b1);
      query("realloc_hit", 32'h1004, 1'b1, 32'h5004);
`endif

      query("other_set_intact", 32'h1400, 1'b1, 32'h2800);
      step("qv0_no_pred", 1'b0, 32'h1400, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

      step("flush_cycle", 1'b1, 32'h1400, 1'b1, 32'h3000, 32'h4000, 1'b1, 1'b1, 1'b0, 32'h0);
      query("flush_1400", 32'h1400, 1'b0, 32'h0);
      query("flush_1600", 32'h1600, 1'b0, 32'h0);
      query("flush_1004", 32'h1004, 1'b0, 32'h0);
      query("flush_3000", 32'h3000, 1'b0, 32'h0);

      // After flush the set refills from way 0 and RR restarts at 0.
      update("refill_1000", 32'h1000, 32'h7000, 1'b1);
      update("refill_1200", 32'h1200, 32'h7200, 1'b1);
      update("refill_1400", 32'h1400, 32'h7400, 1'b1);
      query("refill_evict", 32'h1000, 1'b0, 32'h0);
      query("refill_hit", 32'h1200, 1'b1, 32'h7200);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
